// File: rtl/text_msg_writer.sv
// Writes one of four fixed text messages into a tile-based text RAM, one
// character per clock, then pulses done. Clear-screen fills every cell with 00.
module text_msg_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  msg_sel,
  input  logic [3:0]  dig1,
  input  logic [3:0]  dig0,
  input  logic [1:0]  ball,
  output logic        we,
  output logic [11:0] wr_addr,
  output logic [6:0]  wr_data,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t     state;
  logic [1:0] lat_sel;
  logic [3:0] lat_dig1;
  logic [3:0] lat_dig0;
  logic [1:0] lat_ball;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic [4:0] next_row;
  logic [6:0] next_col;
  logic       is_last;

  // Each message occupies a rectangular window of the screen.
  function automatic logic [4:0] first_row(input logic [1:0] sel);
    case (sel)
      2'd1:    return 5'd12;
      2'd2:    return 5'd14;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [6:0] first_col(input logic [1:0] sel);
    case (sel)
      2'd1:    return 7'd32;
      2'd2:    return 7'd35;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [4:0] last_row(input logic [1:0] sel);
    case (sel)
      2'd0:    return 5'd0;
      2'd1:    return 5'd15;
      2'd2:    return 5'd14;
      default: return LAST_ROW;
    endcase
  endfunction

  function automatic logic [6:0] last_col(input logic [1:0] sel);
    case (sel)
      2'd0:    return 7'd15;
      2'd1:    return 7'd47;
      2'd2:    return 7'd43;
      default: return LAST_COL;
    endcase
  endfunction

  // Each message row is packed as 16 bytes, leftmost character in the top byte.
  function automatic logic [6:0] char_for(input logic [1:0] sel, input logic [3:0] d1,
                                          input logic [3:0] d0, input logic [1:0] b,
                                          input logic [4:0] r, input logic [6:0] c);
    logic [127:0] line;
    logic [3:0]   off;
    int           idx;
    off  = 4'(c - first_col(sel));
    line = '0;
    case (sel)
      2'd0: line = {"Score:", 4'h3, d1, 4'h3, d0, 16'h0, "Ball:", 6'b001100, b};
      2'd1: begin
        case (2'(r - 5'd12))
          2'd0:    line = {"RULE:", 88'h0};
          2'd1:    line = {"Use two buttons", 8'h0};
          2'd2:    line = {"to move paddle", 16'h0};
          default: line = {"up and down.", 32'h0};
        endcase
      end
      2'd2: line = {"Game", 8'h0, "Over", 56'h0};
      default: line = '0;
    endcase
    idx = 126 - 8 * int'(off);
    return line[idx -: 7];
  endfunction

  always_comb begin
    is_last  = (cur_row == last_row(lat_sel)) && (cur_col == last_col(lat_sel));
    next_row = cur_row;
    next_col = cur_col + 7'd1;
    if (cur_col == last_col(lat_sel)) begin
      next_col = first_col(lat_sel);
      next_row = cur_row + 5'd1;
    end
  end

  // Outputs are registered: the address/data set up on one edge are the
  // write presented during the following cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_data  <= '0;
      cur_row  <= '0;
      cur_col  <= '0;
      lat_sel  <= '0;
      lat_dig1 <= '0;
      lat_dig0 <= '0;
      lat_ball <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= WRITE;
            lat_sel  <= msg_sel;
            lat_dig1 <= dig1;
            lat_dig0 <= dig0;
            lat_ball <= ball;
            cur_row  <= first_row(msg_sel);
            cur_col  <= first_col(msg_sel);
            wr_data  <= char_for(msg_sel, dig1, dig0, ball,
                                 first_row(msg_sel), first_col(msg_sel));
            we       <= 1'b1;
            busy     <= 1'b1;
          end
        end
        WRITE: begin
          if (is_last) begin
            state <= DONE;
            we    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cur_row <= next_row;
            cur_col <= next_col;
            wr_data <= char_for(lat_sel, lat_dig1, lat_dig0, lat_ball, next_row, next_col);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_addr = {cur_row, cur_col};

endmodule

// File: tb/tb_text_msg_writer.sv
// Directed bench for text_msg_writer: each task runs one scenario and checks
// the captured write stream against hand-computed values.
module tb_text_msg_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  msg_sel;
  logic [3:0]  dig1;
  logic [3:0]  dig0;
  logic [1:0]  ball;
  logic        we;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [11:0] waddr[$];
  logic [6:0]  wdata[$];
  logic        we_log[$];
  logic        busy_log[$];
  int          done_cyc;
  int          done_cnt;
  int          busy_bad;

  always #5 clk = ~clk;

  text_msg_writer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_sel(msg_sel),
    .dig1(dig1), .dig0(dig0), .ball(ball), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  // Pulses start, then records every cycle until done (or the budget runs out).
  // inj_kind: 1 = second start with msg_sel=2, 2 = dig0 -> 9, 3 = reset pulse.
  task automatic run_msg(input logic [1:0] sel, input logic [3:0] d1, input logic [3:0] d0,
                         input logic [1:0] b, input int budget, input int inj_kind,
                         input int inj_cyc);
    waddr.delete(); wdata.delete(); we_log.delete(); busy_log.delete();
    done_cyc = -1; done_cnt = 0; busy_bad = 0;
    @(negedge clk);
    msg_sel = sel; dig1 = d1; dig0 = d0; ball = b; start = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      we_log.push_back(we);
      busy_log.push_back(busy);
      if (we) begin waddr.push_back(wr_addr); wdata.push_back(wr_data); end
      if (busy !== we) busy_bad++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (cyc == 1) start = 1'b0;
      if (inj_kind == 1 && cyc == inj_cyc) begin start = 1'b1; msg_sel = 2'd2; end
      if (inj_kind == 1 && cyc == inj_cyc + 1) start = 1'b0;
      if (inj_kind == 2 && cyc == inj_cyc) dig0 = 4'd9;
      if (inj_kind == 3 && cyc == inj_cyc) reset_n = 1'b0;
      if (inj_kind == 3 && cyc == inj_cyc + 1) reset_n = 1'b1;
      if (done && inj_kind != 1) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b1; msg_sel = 2'd0; dig1 = 0; dig0 = 0; ball = 0;
    repeat (3) @(negedge clk);
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (wr_addr !== 12'h000) begin errors++; $display("[TB] FAIL reset_addr got %h want 000", wr_addr); end
    checks++; if (wr_data !== 7'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", wr_data); end
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++; if (we !== 1'b0) begin errors++; $display("[TB] FAIL reset_priority_we got %b want 0", we); end
  endtask

  task automatic test_score;
    int bad;
    run_msg(2'd0, 4'd4, 4'd2, 2'd3, 40, 0, 0);
    checks++; if (waddr.size() !== 16) begin errors++; $display("[TB] FAIL score_count got %0d want 16", waddr.size()); end
    if (waddr.size() == 16) begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (waddr[i] !== 12'(i)) bad++;
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL score_addrs got %0d bad want 0", bad); end
      checks++; if (wdata[0] !== 7'h53) begin errors++; $display("[TB] FAIL score_col0 got %h want 53", wdata[0]); end
      checks++; if (wdata[6] !== 7'h34) begin errors++; $display("[TB] FAIL score_col6 got %h want 34", wdata[6]); end
      checks++; if (wdata[7] !== 7'h32) begin errors++; $display("[TB] FAIL score_col7 got %h want 32", wdata[7]); end
      checks++; if (wdata[8] !== 7'h00) begin errors++; $display("[TB] FAIL score_col8 got %h want 00", wdata[8]); end
      checks++; if (wdata[10] !== 7'h42) begin errors++; $display("[TB] FAIL score_col10 got %h want 42", wdata[10]); end
      checks++; if (wdata[15] !== 7'h33) begin errors++; $display("[TB] FAIL score_col15 got %h want 33", wdata[15]); end
    end
    checks++; if (done_cyc !== 17) begin errors++; $display("[TB] FAIL score_done_cycle got %0d want 17", done_cyc); end
    checks++; if (busy_bad !== 0) begin errors++; $display("[TB] FAIL score_busy got %0d bad cycles want 0", busy_bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL score_done_width got %b want 0", done); end
    checks++; if (wr_addr !== 12'h00F) begin errors++; $display("[TB] FAIL score_hold_addr got %h want 00f", wr_addr); end
    checks++; if (wr_data !== 7'h33) begin errors++; $display("[TB] FAIL score_hold_data got %h want 33", wr_data); end
  endtask

  task automatic test_game_over;
    run_msg(2'd2, 4'd0, 4'd0, 2'd0, 30, 0, 0);
    checks++; if (waddr.size() !== 9) begin errors++; $display("[TB] FAIL go_count got %0d want 9", waddr.size()); end
    if (waddr.size() == 9) begin
      checks++; if (waddr[0] !== 12'h723) begin errors++; $display("[TB] FAIL go_first_addr got %h want 723", waddr[0]); end
      checks++; if (wdata[0] !== 7'h47) begin errors++; $display("[TB] FAIL go_first_data got %h want 47", wdata[0]); end
      checks++; if (wdata[4] !== 7'h00) begin errors++; $display("[TB] FAIL go_space got %h want 00", wdata[4]); end
      checks++; if (waddr[8] !== 12'h72B) begin errors++; $display("[TB] FAIL go_last_addr got %h want 72b", waddr[8]); end
      checks++; if (wdata[8] !== 7'h72) begin errors++; $display("[TB] FAIL go_last_data got %h want 72", wdata[8]); end
    end
    checks++; if (done_cyc !== 10) begin errors++; $display("[TB] FAIL go_done_cycle got %0d want 10", done_cyc); end
  endtask

  task automatic test_rule;
    run_msg(2'd1, 4'd0, 4'd0, 2'd0, 100, 0, 0);
    checks++; if (waddr.size() !== 64) begin errors++; $display("[TB] FAIL rule_count got %0d want 64", waddr.size()); end
    if (waddr.size() == 64) begin
      checks++; if (waddr[0] !== 12'h620) begin errors++; $display("[TB] FAIL rule_addr0 got %h want 620", waddr[0]); end
      checks++; if (waddr[16] !== 12'h6A0) begin errors++; $display("[TB] FAIL rule_addr16 got %h want 6a0", waddr[16]); end
      checks++; if (waddr[63] !== 12'h7AF) begin errors++; $display("[TB] FAIL rule_addr63 got %h want 7af", waddr[63]); end
      checks++; if (wdata[0] !== 7'h52) begin errors++; $display("[TB] FAIL rule_data0 got %h want 52", wdata[0]); end
      checks++; if (wdata[5] !== 7'h00) begin errors++; $display("[TB] FAIL rule_data5 got %h want 00", wdata[5]); end
      checks++; if (wdata[16] !== 7'h55) begin errors++; $display("[TB] FAIL rule_data16 got %h want 55", wdata[16]); end
      checks++; if (wdata[47] !== 7'h00) begin errors++; $display("[TB] FAIL rule_data47 got %h want 00", wdata[47]); end
      checks++; if (wdata[48] !== 7'h75) begin errors++; $display("[TB] FAIL rule_data48 got %h want 75", wdata[48]); end
      checks++; if (wdata[59] !== 7'h2E) begin errors++; $display("[TB] FAIL rule_data59 got %h want 2e", wdata[59]); end
    end
    checks++; if (done_cyc !== 65) begin errors++; $display("[TB] FAIL rule_done_cycle got %0d want 65", done_cyc); end
  endtask

  task automatic test_clear;
    int nonzero;
    run_msg(2'd3, 4'd7, 4'd7, 2'd1, 2500, 0, 0);
    checks++; if (waddr.size() !== 2400) begin errors++; $display("[TB] FAIL clear_count got %0d want 2400", waddr.size()); end
    if (waddr.size() == 2400) begin
      nonzero = 0;
      foreach (wdata[i]) if (wdata[i] !== 7'h00) nonzero++;
      checks++; if (nonzero !== 0) begin errors++; $display("[TB] FAIL clear_data got %0d nonzero want 0", nonzero); end
      checks++; if (waddr[79] !== 12'h04F) begin errors++; $display("[TB] FAIL clear_addr79 got %h want 04f", waddr[79]); end
      checks++; if (waddr[80] !== 12'h080) begin errors++; $display("[TB] FAIL clear_wrap got %h want 080", waddr[80]); end
      checks++; if (waddr[2399] !== 12'hECF) begin errors++; $display("[TB] FAIL clear_last got %h want ecf", waddr[2399]); end
    end
    checks++; if (done_cyc !== 2401) begin errors++; $display("[TB] FAIL clear_done_cycle got %0d want 2401", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL clear_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_busy_start;
    run_msg(2'd0, 4'd1, 4'd2, 2'd1, 45, 1, 5);
    checks++; if (waddr.size() !== 16) begin errors++; $display("[TB] FAIL busy_start_count got %0d want 16", waddr.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL busy_start_dones got %0d want 1", done_cnt); end
    if (waddr.size() == 16) begin
      checks++; if (waddr[15] !== 12'h00F) begin errors++; $display("[TB] FAIL busy_start_last got %h want 00f", waddr[15]); end
    end
  endtask

  task automatic test_input_change;
    run_msg(2'd0, 4'd1, 4'd5, 2'd2, 40, 2, 2);
    checks++; if (waddr.size() !== 16) begin errors++; $display("[TB] FAIL latch_count got %0d want 16", waddr.size()); end
    if (waddr.size() == 16) begin
      checks++; if (wdata[7] !== 7'h35) begin errors++; $display("[TB] FAIL latch_dig0 got %h want 35", wdata[7]); end
    end
  endtask

  task automatic test_hex_digits;
    run_msg(2'd0, 4'd15, 4'd10, 2'd0, 40, 0, 0);
    if (waddr.size() == 16) begin
      checks++; if (wdata[6] !== 7'h3F) begin errors++; $display("[TB] FAIL hex_dig1 got %h want 3f", wdata[6]); end
      checks++; if (wdata[7] !== 7'h3A) begin errors++; $display("[TB] FAIL hex_dig0 got %h want 3a", wdata[7]); end
      checks++; if (wdata[15] !== 7'h30) begin errors++; $display("[TB] FAIL hex_ball got %h want 30", wdata[15]); end
    end else begin
      checks++; errors++; $display("[TB] FAIL hex_count got %0d want 16", waddr.size());
    end
  endtask

  task automatic test_back_to_back;
    run_msg(2'd0, 4'd3, 4'd3, 2'd3, 40, 0, 0);
    run_msg(2'd2, 4'd0, 4'd0, 2'd0, 30, 0, 0);
    checks++; if (waddr.size() !== 9) begin errors++; $display("[TB] FAIL b2b_count got %0d want 9", waddr.size()); end
    checks++; if (done_cyc !== 10) begin errors++; $display("[TB] FAIL b2b_done_cycle got %0d want 10", done_cyc); end
  endtask

  task automatic test_midop_reset;
    run_msg(2'd1, 4'd0, 4'd0, 2'd0, 70, 3, 20);
    checks++; if (waddr.size() !== 20) begin errors++; $display("[TB] FAIL abort_count got %0d want 20", waddr.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_done got %0d want 0", done_cnt); end
    if (we_log.size() > 20) begin
      checks++; if (we_log[20] !== 1'b0) begin errors++; $display("[TB] FAIL abort_we got %b want 0", we_log[20]); end
      checks++; if (busy_log[20] !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy_log[20]); end
    end
    run_msg(2'd0, 4'd6, 4'd7, 2'd1, 40, 0, 0);
    checks++; if (waddr.size() !== 16) begin errors++; $display("[TB] FAIL post_abort_count got %0d want 16", waddr.size()); end
    checks++; if (done_cyc !== 17) begin errors++; $display("[TB] FAIL post_abort_done got %0d want 17", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_score();
    test_game_over();
    test_rule();
    test_clear();
    test_busy_start();
    test_input_change();
    test_hex_digits();
    test_back_to_back();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_msg_writer.md
TEXT_MSG_WRITER -- requirements
Module: text_msg_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning text-RAM tile columns (640 px / 8).
REQ-002 SHALL have parameter ROWS, default 30, meaning text-RAM tile rows (480 px / 16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-006 SHALL have port msg_sel  input  2  0=score line, 1=rule block, 2=game over, 3=clear screen.
REQ-007 SHALL have ports dig1, dig0  input  4 each  score tens/units digits.
REQ-008 SHALL have port ball  input  2  balls remaining.
REQ-009 SHALL have port we  output  1  text-RAM write enable.
REQ-010 SHALL have port wr_addr  output  12  text-RAM address {row[4:0], col[6:0]}.
REQ-011 SHALL have port wr_data  output  7  ASCII character code.
REQ-012 SHALL have port busy  output  1  high from the cycle after start acceptance until the last write.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, DONE; IDLE->WRITE on start, WRITE->DONE after the final character, DONE->IDLE unconditionally next cycle.
REQ-015 SHALL latch msg_sel, dig1, dig0 and ball on start acceptance; input changes afterwards have no effect on the current message.
REQ-016 SHALL ignore start in WRITE and DONE (no queuing).
REQ-017 SHALL assert we for exactly one character per cycle in WRITE, first write in the cycle after start is sampled.
REQ-018 SHALL, for msg_sel=0, write 16 chars at row 0, cols 0..15: "Score:" (53 63 6f 72 65 3a), {3'b011,dig1}, {3'b011,dig0}, 00, 00, "Ball:" (42 61 6c 6c 3a), {5'b01100,ball}.
REQ-019 SHALL, for msg_sel=1, write 64 chars, rows 12..15, cols 32..47, row-major: "RULE:" padded with 00; "Use two buttons" + 00; "to move paddle" + 00 00; "up and down." + 00 x4.
REQ-020 SHALL, for msg_sel=2, write 9 chars at row 14, cols 35..43: "Game Over" (47 61 6d 65 00 4f 76 65 72).
REQ-021 SHALL, for msg_sel=3, write 00 to every cell, row 0..ROWS-1, col 0..COLS-1, row-major; column counter wraps COLS-1->0 with row increment; total ROWS*COLS writes.
REQ-022 SHALL use digit values 10..15 unchecked (code = 0x30+dig).
REQ-023 SHALL hold wr_addr and wr_data at their last values and we=0 outside WRITE.
REQ-024 SHALL assert done for exactly one cycle (DONE state), with busy=0 and we=0 in that cycle.
REQ-025 SHALL give total latency start-sample -> done = N+1 cycles, N = character count (16, 64, 9, ROWS*COLS).
REQ-026 SHALL accept a new start in the cycle after done (IDLE).

Reset
REQ-027 SHALL, while reset_n=0 at a clock edge, enter IDLE with we=0, busy=0, done=0, wr_addr=0, wr_data=0, counters 0.
REQ-028 SHALL abort an in-progress message on reset without further writes and without a done pulse.
REQ-029 SHALL give reset priority over a simultaneous start.

Verification
REQ-030 Score: dig1=4, dig0=2, ball=3, msg_sel=0, start 1 cycle -> 16 writes addr 0x000..0x00F, data at cols 6,7,15 = 0x34,0x32,0x33; done at cycle 17.
REQ-031 Game over: msg_sel=2 -> 9 writes, first addr {14,35}=0x723 data 0x47, last 0x72B data 0x72; done at cycle 10.
REQ-032 Clear: msg_sel=3 -> 2400 writes, all data 0x00, col 79->0 wrap with row increment (0x04F -> 0x080), last addr 0xECF; done once.
REQ-033 Busy start: start again mid score write with msg_sel=2 -> ignored; only 16 score writes, one done.
REQ-034 Input change: dig0 changed 5->9 after start -> col 7 still written 0x35.
REQ-035 Mid-op reset: reset_n low at rule write 20 -> next cycle we=0, busy=0, no done; subsequent start msg_sel=0 completes normally.
